// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: valid/ready request in, one-cycle response strobe out.
// Optional bus timeout compiled in with `define WB_INITIATOR_TIMEOUT_EN.
module wb_initiator #(
    parameter int unsigned AW      = 7,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [3:0]    req_be_i,
    input  logic [AW-1:0] req_adr_i,
    input  logic [31:0]   req_dat_i,

    output logic          rsp_valid_o,
    output logic [31:0]   rsp_dat_o,
    output logic          rsp_err_o,

    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [3:0]    be_o,
    output logic [AW-1:0] adr_o,
    output logic [31:0]   dat_o,
    input  logic          ack_i,
    input  logic [31:0]   dat_i
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_initiator: TIMEOUT must be within 1..65535");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   accept;
    logic   finish_ok;
    logic   finish_err;
    logic   timeout_hit;

`ifdef WB_INITIATOR_TIMEOUT_EN
    // Counter holds the number of unacked BUS cycles already completed, so the
    // current BUS cycle is number cnt_q+1; abort when that reaches TIMEOUT.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q == BUS && !ack_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign req_ready_o = (state_q == IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ack wins over a coincident timeout
                if (ack_i) begin
                    finish_ok = 1'b1;
                    state_d   = IDLE;
                end else if (timeout_hit) begin
                    finish_err = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            be_o  <= '0;
            adr_o <= '0;
            dat_o <= '0;
        end else if (accept) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= req_we_i;
            be_o  <= req_be_i;
            adr_o <= req_adr_i;
            dat_o <= req_dat_i;
        end else if (finish_ok || finish_err) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
        end else begin
            rsp_valid_o <= finish_ok || finish_err;
            if (finish_ok) begin
                rsp_dat_o <= dat_i;
            end else if (finish_err) begin
                rsp_dat_o <= '0;
            end
        end
    end

`ifdef WB_INITIATOR_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_err_o <= 1'b0;
        end else begin
            rsp_err_o <= finish_err;
        end
    end
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator against a registered-ack RAM responder
// plus a manually driven ack/data path for idle, reset and timeout cases.
module tb_wb_initiator;

    localparam int AW = 7;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [3:0]    req_be_i;
    logic [AW-1:0] req_adr_i;
    logic [31:0]   req_dat_i;
    logic          rsp_valid_o;
    logic [31:0]   rsp_dat_o;
    logic          rsp_err_o;
    logic          cyc_o, stb_o, we_o;
    logic [3:0]    be_o;
    logic [AW-1:0] adr_o;
    logic [31:0]   dat_o;
    logic          ack_i;
    logic [31:0]   dat_i;

    logic          ram_mode;
    logic          ram_ack;
    logic [31:0]   ram_rdata;
    logic          man_ack;
    logic [31:0]   man_dat;
    logic [31:0]   mem [0:127];

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    wb_initiator #(.AW(AW), .TIMEOUT(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_be_i(req_be_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .be_o(be_o),
        .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
    );

    // Registered-ack RAM responder: ack one cycle after cyc&stb, for one cycle.
    always @(posedge clk_i) begin
        if (ram_mode && cyc_o && stb_o && !ram_ack) begin
            ram_ack   <= 1'b1;
            ram_rdata <= mem[adr_o];
            if (we_o) begin
                for (int b = 0; b < 4; b++)
                    if (be_o[b]) mem[adr_o][8*b +: 8] <= dat_o[8*b +: 8];
            end
        end else begin
            ram_ack <= 1'b0;
        end
    end

    assign ack_i = ram_mode ? ram_ack   : man_ack;
    assign dat_i = ram_mode ? ram_rdata : man_dat;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [3:0] be, input logic [AW-1:0] adr,
                       input logic [31:0] dat, output logic [31:0] rd, output logic err,
                       output int lat, output int cyc_n);
        req_we_i    = we;
        req_be_i    = be;
        req_adr_i   = adr;
        req_dat_i   = dat;
        req_valid_i = 1'b1;
        step;
        req_valid_i = 1'b0;
        lat   = 0;
        cyc_n = 0;
        while (!rsp_valid_o && lat < 20) begin
            if (cyc_o) cyc_n++;
            step;
            lat++;
        end
        rd  = rsp_dat_o;
        err = rsp_err_o;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat, cyc_n;
        int          seen, i, k, n, last, idle, viol;
        logic        hs;

        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_be_i    = 4'h0;
        req_adr_i   = '0;
        req_dat_i   = 32'h0;
        ram_mode    = 1'b1;
        man_ack     = 1'b0;
        man_dat     = 32'h0;
        ram_ack     = 1'b0;
        ram_rdata   = 32'h0;

        // Reset values before any clock edge
        #3;
        chk("rst_cyc", {31'h0, cyc_o}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_outs", {be_o, adr_o, we_o, stb_o, rsp_err_o}, 32'h0);
        chk("rst_dat_o", dat_o, 32'h0);
        chk("rst_rsp_dat", rsp_dat_o, 32'h0);
        step;
        step;
        rst_ni = 1'b1;
        step;
        chk("ready_after_rst", {31'h0, req_ready_o}, 32'h1);

        // Full-word write
        req_we_i = 1'b1; req_be_i = 4'hF; req_adr_i = 7'h05; req_dat_i = 32'hDEADBEEF;
        req_valid_i = 1'b1;
        step;
        req_valid_i = 1'b0;
        chk("wr_bus_outs", {cyc_o, stb_o, we_o, be_o, adr_o, req_ready_o}, {1'b1, 1'b1, 1'b1, 4'hF, 7'h05, 1'b0});
        chk("wr_dat_o", dat_o, 32'hDEADBEEF);
        step;
        chk("wr_cyc_2nd", {30'h0, cyc_o, rsp_valid_o}, 32'h2);
        step;
        chk("wr_rsp", {29'h0, cyc_o, rsp_valid_o, rsp_err_o}, 32'h2);
        chk("wr_ready_back", {31'h0, req_ready_o}, 32'h1);
        step;
        chk("wr_rsp_pulse", {31'h0, rsp_valid_o}, 32'h0);

        txn(1'b0, 4'hF, 7'h05, 32'h0, rd, err, lat, cyc_n);
        chk("rd1_dat", rd, 32'hDEADBEEF);
        chk("rd1_lat", lat, 32'd2);

        txn(1'b1, 4'h1, 7'h05, 32'h000000AA, rd, err, lat, cyc_n);
        chk("wrb_err", {31'h0, err}, 32'h0);
        txn(1'b0, 4'hF, 7'h05, 32'h0, rd, err, lat, cyc_n);
        chk("rd2_dat", rd, 32'hDEADBEAA);
        chk("rd2_cyc_n", cyc_n, 32'd2);

        // Preload 1..4, then four back-to-back reads with valid held high
        for (int a = 1; a <= 4; a++) begin
            txn(1'b1, 4'hF, AW'(a), 32'hA000_0000 | 32'(a), rd, err, lat, cyc_n);
        end
        req_we_i = 1'b0; req_be_i = 4'hF; req_adr_i = 7'h01; req_valid_i = 1'b1;
        i = 0; k = 0; n = 0; last = 0; idle = 0; viol = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            hs = req_ready_o && req_valid_i;
            step;
            n++;
            if (hs) begin
                i++;
                if (i == 4) req_valid_i = 1'b0;
                else req_adr_i = AW'(i + 1);
            end
            if (req_ready_o === cyc_o) viol++;
            if (!cyc_o) idle++;
            if (rsp_valid_o) begin
                chk("b2b_dat", rsp_dat_o, 32'hA000_0000 | 32'(k + 1));
                k++;
                last = n;
            end
        end
        chk("b2b_count", k, 32'd4);
        chk("b2b_last_rsp", last, 32'd12);
        chk("b2b_idle_cycles", idle, 32'd4);
        chk("b2b_ready_vs_bus", viol, 32'd0);

        // Spurious ack while idle
        ram_mode = 1'b0; man_ack = 1'b1; man_dat = 32'hCAFEF00D;
        seen = 0;
        repeat (3) begin
            step;
            if (rsp_valid_o || cyc_o || !req_ready_o) seen++;
        end
        chk("idle_ack_ignored", seen, 32'd0);
        man_ack = 1'b0;

        // Reset asserted between edges during BUS
        req_we_i = 1'b0; req_adr_i = 7'h05; req_valid_i = 1'b1;
        step;
        req_valid_i = 1'b0;
        chk("mid_rst_pre_cyc", {31'h0, cyc_o}, 32'h1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_drop", {27'h0, cyc_o, stb_o, rsp_valid_o, req_ready_o, 1'b0}, 32'h2);
        chk("mid_rst_adr", {25'h0, adr_o}, 32'h0);
        #2 rst_ni = 1'b1;
        man_ack = 1'b1;
        seen = 0;
        repeat (3) begin
            step;
            if (rsp_valid_o || cyc_o) seen++;
        end
        chk("mid_rst_no_rsp", seen, 32'd0);
        man_ack = 1'b0;
        ram_mode = 1'b1;
        txn(1'b0, 4'hF, 7'h05, 32'h0, rd, err, lat, cyc_n);
        chk("post_rst_dat", rd, 32'hDEADBEAA);
        chk("post_rst_lat", lat, 32'd2);

        ram_mode = 1'b0; man_ack = 1'b0; man_dat = 32'h12345678;
`ifdef WB_INITIATOR_TIMEOUT_EN
        txn(1'b0, 4'hF, 7'h09, 32'h0, rd, err, lat, cyc_n);
        chk("to_cyc_n", cyc_n, 32'd3);
        chk("to_err", {31'h0, err}, 32'h1);
        chk("to_dat", rd, 32'h0);
        chk("to_cyc_low", {31'h0, cyc_o}, 32'h0);
        req_valid_i = 1'b1;
        step;
        req_valid_i = 1'b0;
        step;
        step;
        man_ack = 1'b1;
        step;
        man_ack = 1'b0;
        chk("to_ack_prio", {30'h0, rsp_valid_o, rsp_err_o}, 32'h2);
        chk("to_ack_dat", rsp_dat_o, 32'h12345678);
`else
        req_valid_i = 1'b1;
        step;
        req_valid_i = 1'b0;
        seen = 0;
        repeat (10) begin
            step;
            if (rsp_valid_o || !cyc_o) seen++;
        end
        chk("no_to_waits", seen, 32'd0);
        man_ack = 1'b1;
        step;
        man_ack = 1'b0;
        chk("no_to_rsp", {30'h0, rsp_valid_o, rsp_err_o}, 32'h2);
        chk("no_to_dat", rsp_dat_o, 32'h12345678);
`endif

        step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter AW, default 7: Wishbone word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum bus cycles to wait for ack_i, legal range 1..65535.
REQ-003 SHALL have port clk_i  input  1: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_ni  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1: request present.
REQ-006 SHALL have port req_ready_o  output  1: request accepted when both valid and ready are high at a clock edge.
REQ-007 SHALL have ports req_we_i  input  1, req_be_i  input  4, req_adr_i  input  AW, req_dat_i  input  32: request write flag, byte enables, word address and write data.
REQ-008 SHALL have ports rsp_valid_o  output  1, rsp_dat_o  output  32, rsp_err_o  output  1: response strobe, read data and error flag.
REQ-009 SHALL have ports cyc_o, stb_o, we_o  output  1; be_o  output  4; adr_o  output  AW; dat_o  output  32: Wishbone classic initiator outputs.
REQ-010 SHALL have ports ack_i  input  1 and dat_i  input  32: Wishbone responder ack and read data.

Function
REQ-011 SHALL implement states IDLE and BUS; req_ready_o = 1 exactly when state is IDLE.
REQ-012 SHALL, on handshake in IDLE, register we/be/adr/dat onto we_o/be_o/adr_o/dat_o, assert cyc_o and stb_o from the next cycle, and enter BUS.
REQ-013 SHALL hold we_o, be_o, adr_o and dat_o stable and cyc_o = stb_o = 1 for every cycle spent in BUS.
REQ-014 SHALL, on an edge in BUS with ack_i = 1, capture dat_i into rsp_dat_o, deassert cyc_o and stb_o, pulse rsp_valid_o for exactly one cycle with rsp_err_o = 0, and return to IDLE.
REQ-015 SHALL, for write cycles, still capture dat_i into rsp_dat_o; software ignores it.
REQ-016 SHALL ignore ack_i while in IDLE: no response and no state change.
REQ-017 SHALL allow back-to-back requests: a new handshake is accepted in the same cycle rsp_valid_o is high, giving a one-cycle gap with cyc_o = 0 between bus cycles.
REQ-018 SHALL, against a responder with registered ack, produce rsp_valid_o two cycles after the handshake edge.
REQ-019 SHALL NOT provide response backpressure; the consumer takes rsp_* in the cycle rsp_valid_o is high.

Reset
REQ-020 SHALL, while rst_ni = 0, force state IDLE and drive cyc_o, stb_o, we_o, be_o, adr_o, dat_o, rsp_valid_o, rsp_dat_o and rsp_err_o to 0, with no clock edge required.
REQ-021 SHALL, on reset during BUS, drop cyc_o and stb_o immediately, abandon the transfer and produce no response.
REQ-022 SHALL leave req_ready_o = 1 after reset release and SHALL hold the timeout counter at 0 during reset.

Configuration
REQ-023 SHALL compile the bus-timeout feature only when macro WB_INITIATOR_TIMEOUT_EN is defined.
REQ-024 SHALL, with WB_INITIATOR_TIMEOUT_EN defined, clear a cycle counter on entry to BUS and increment it each BUS cycle without ack_i.
REQ-025 SHALL, with WB_INITIATOR_TIMEOUT_EN defined, abort when the counter equals TIMEOUT with ack_i = 0: drop cyc_o/stb_o, pulse rsp_valid_o with rsp_err_o = 1 and rsp_dat_o = 0, and return to IDLE.
REQ-026 SHALL, with WB_INITIATOR_TIMEOUT_EN defined, give ack_i priority when ack_i = 1 in the cycle the counter equals TIMEOUT: normal response with rsp_err_o = 0.
REQ-027 SHALL, without WB_INITIATOR_TIMEOUT_EN, wait in BUS indefinitely, tie rsp_err_o to 0, and contain no counter logic.

Verification
REQ-028 SHALL cover: write adr 0x05, data 0xDEADBEEF, be 0xF to a registered-ack RAM responder -> one cyc_o burst of 2 cycles, rsp_valid_o 2 cycles after handshake, rsp_err_o = 0.
REQ-029 SHALL cover: read adr 0x05 after that write -> rsp_dat_o = 0xDEADBEEF; then write be 0x1, data 0x000000AA and read back -> 0xDEADBEAA.
REQ-030 SHALL cover: req_valid_i held high for 4 back-to-back reads -> 4 responses in order, one idle cycle with cyc_o = 0 between bus cycles, req_ready_o low only in BUS.
REQ-031 SHALL cover: TIMEOUT=3, macro defined, responder never acks -> cyc_o high 3 cycles, rsp_valid_o with rsp_err_o = 1 and rsp_dat_o = 0; a second run with ack at count 3 -> rsp_err_o = 0.
REQ-032 SHALL cover: rst_ni pulled low mid-BUS between clock edges -> cyc_o/stb_o = 0 immediately, no rsp_valid_o after release, next request completes normally.
REQ-033 SHALL cover: spurious ack_i = 1 in IDLE -> no rsp_valid_o and state unchanged.
